// File: rtl/lutram_bit_reader.sv
// Streams bits from a 128x1 asynchronous-read LUT RAM and packs them LSB-first into WORD_BITS-wide words.
// Optional macro LUTRAM_BIT_READER_PARITY_EN adds an out_parity output (XOR of out_data).
module lutram_bit_reader #(
    parameter int WORD_BITS = 8
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 start,
    input  logic [6:0]           start_addr,
    input  logic [4:0]           num_words,
    output logic [6:0]           rd_addr,
    input  logic                 rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_BITS-1:0] out_data,
    output logic                 busy,
    output logic                 done
`ifdef LUTRAM_BIT_READER_PARITY_EN
    ,
    output logic                 out_parity
`endif
);

    localparam int CNT_W = $clog2(WORD_BITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        OUTPUT,
        FINISH
    } state_t;

    state_t               state_reg, state_next;
    logic [6:0]           ptr_reg, ptr_next;
    logic [4:0]           words_left_reg, words_left_next;
    logic [CNT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [WORD_BITS-1:0] shift_reg, shift_next;
    logic                 last_bit;

    assign last_bit = (bit_cnt_reg == CNT_W'(WORD_BITS - 1));

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            words_left_reg <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            words_left_reg <= words_left_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        words_left_next = words_left_reg;
        bit_cnt_next    = bit_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (num_words != 5'd0) begin
                        ptr_next        = start_addr;
                        words_left_next = num_words;
                        bit_cnt_next    = '0;
                        state_next      = FETCH;
                    end else begin
                        state_next = FINISH;
                    end
                end
            end
            FETCH: begin
                // 7-bit pointer wraps 127 -> 0 naturally
                ptr_next     = ptr_reg + 7'd1;
                bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                if (last_bit) begin
                    state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    words_left_next = words_left_reg - 5'd1;
                    bit_cnt_next    = '0;
                    state_next      = (words_left_reg == 5'd1) ? FINISH : FETCH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Each shift-register bit captures rd_data only on the FETCH cycle addressing it.
    generate
        for (genvar gi = 0; gi < WORD_BITS; gi++) begin : g_shift
            assign shift_next[gi] = (state_reg == FETCH && bit_cnt_reg == CNT_W'(gi))
                                    ? rd_data : shift_reg[gi];
        end
    endgenerate

    assign rd_addr   = ptr_reg;
    assign out_data  = shift_reg;
    assign out_valid = (state_reg == OUTPUT);
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == FINISH);

`ifdef LUTRAM_BIT_READER_PARITY_EN
    assign out_parity = ^shift_reg;
`endif

endmodule
